rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
//   Parametrised time-of-day counter: hh:mm:ss plus a clk-derived 1 Hz prescaler.
//   Adds run/freeze, a validated time-set interface, 12/24 h display and tick strobes.
//   Carries all units in a single edge, so there is no one-cycle ripple lag between units.
//   Sits between the board clock and the display/driver logic.
// PARAMETERS
//   CLK_HZ      100_000_000  input clock frequency; prescaler wraps at CLK_HZ-1
//   PRESC_W     27           prescaler width; must satisfy 2**PRESC_W >= CLK_HZ
//   HOURS_DAY   24           hour wrap value, 1..24
// PORTS
//   clk        in   1        system clock, rising edge
//   reset_n    in   1        asynchronous, active-high reset (despite the name)
//   run_en     in   1        1 = prescaler and time advance; 0 = frozen
//   mode_12h   in   1        display mode: 1 = 12 h, 0 = 24 h
//   set_valid  in   1        load request, sampled on each rising edge
//   set_hour   in   5        load value, hours
//   set_min    in   6        load value, minutes
//   set_sec    in   6        load value, seconds
//   set_err    out  1        1-cycle pulse: load rejected because a value is out of range
//   sec_count  out  PRESC_W  prescaler value
//   second     out  6        0..59
//   minute     out  6        0..59
//   hour       out  5        0..HOURS_DAY-1, always 24 h encoding
//   disp_hour  out  5        mode-converted hour (combinational from hour)
//   pm         out  1        hour >= 12 when mode_12h=1, else 0
//   sec_tick   out  1        1-cycle pulse on each second increment
//   day_tick   out  1        1-cycle pulse on the HOURS_DAY-1:59:59 -> 00:00:00 wrap
//   alarm_hour in   5        alarm hour (see CONFIGURATION)
//   alarm_min  in   6        alarm minute
//   alarm_arm  in   1        alarm enable
//   alarm_clr  in   1        clears alarm_flag
//   alarm_flag out  1        sticky alarm indicator
// BEHAVIOUR
// - Reset (async, reset_n=1): all registers clear to 0.
//   - Outputs are 0 except disp_hour, which is 12 if mode_12h=1.
//   - Reset takes effect immediately, including mid-count or mid-load.
// - Prescaler (run_en=1):
//   - sec_count increments each edge.
//   - At CLK_HZ-1 it wraps to 0 and the same edge advances second.
//   - sec_tick is registered high for exactly that cycle.
// - Carry, all on the same edge:
//   - second 59 -> 0 with minute+1.
//   - minute 59 -> 0 with hour+1.
//   - hour HOURS_DAY-1 -> 0 with day_tick=1.
//   - Values never exceed their maximum, not even for one cycle.
// - Freeze (run_en=0): sec_count and time hold; ticks are 0; loads are still accepted.
// - Load, on an edge with set_valid=1:
//   - Accepted if set_hour < HOURS_DAY, set_min < 60 and set_sec < 60.
//     Time takes the set values and sec_count clears to 0; visible the next cycle.
//   - Otherwise: no state change, set_err=1 for one cycle.
//   - A load coincident with a prescaler wrap wins: no increment and no ticks that cycle.
//   - set_valid held high reloads on every edge, which keeps the prescaler at 0.
// - 12 h conversion: hour 0 -> 12; 1..12 -> same; 13..23 -> hour-12.
//   - pm=1 for hour >= 12. disp_hour=hour and pm=0 when mode_12h=0.
//   - Changing mode_12h has zero cycles of latency and no effect on the count.
// CONFIGURATION
// - RTC_ALARM_EN defined:
//   - alarm_flag is set on the counting edge where time becomes alarm_hour:alarm_min:00
//     while alarm_arm=1.
//   - The flag is sticky until alarm_clr=1. If clr and set coincide, set wins.
//   - A load never sets the flag. Reset clears it.
// - RTC_ALARM_EN undefined:
//   - Alarm ports remain present and their inputs are ignored.
//   - alarm_flag is tied to 0; no alarm registers are generated.
// TESTING (CLK_HZ=4 unless noted)
// - Reset mid-count at 05:06:07: assert reset_n -> all outputs 0 the same cycle; disp_hour=12 if mode_12h=1.
// - Load 23:59:58, run 8 clocks -> 23:59:59 then 00:00:00; day_tick 1 cycle at the wrap; sec_tick 2 pulses.
// - Load 24:00:00 or 10:60:00 -> set_err pulse, time unchanged; load 12:00:00 -> pm=1, disp_hour=12.
// - Load asserted on the sec_count=3 edge -> loaded value held, sec_count=0, no sec_tick.
// - run_en=0 for 10 clocks at 01:02:03 -> no change, no ticks; resume -> next second after exactly 4 clocks.
// - RTC_ALARM_EN, alarm 00:01 armed, from 00:00:58 -> flag at 00:01:00; same-cycle clr holds it; clr later clears it.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// rtl/rtc_timekeeper.sv - hh:mm:ss time-of-day counter with 1 Hz prescaler, validated load and 12/24 h display
// Optional alarm comparator is built only when RTC_ALARM_EN is defined.
`timescale 1ns/1ps

module rtc_timekeeper #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int PRESC_W   = 27,
  parameter int HOURS_DAY = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run_en,
  input  logic               mode_12h,
  input  logic               set_valid,
  input  logic [4:0]         set_hour,
  input  logic [5:0]         set_min,
  input  logic [5:0]         set_sec,
  output logic               set_err,
  output logic [PRESC_W-1:0] sec_count,
  output logic [5:0]         second,
  output logic [5:0]         minute,
  output logic [4:0]         hour,
  output logic [4:0]         disp_hour,
  output logic               pm,
  output logic               sec_tick,
  output logic               day_tick,
  input  logic [4:0]         alarm_hour,
  input  logic [5:0]         alarm_min,
  input  logic               alarm_arm,
  input  logic               alarm_clr,
  output logic               alarm_flag
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [4:0]         HOUR_MAX  = 5'(HOURS_DAY - 1);
  localparam logic [5:0]         HOUR_LIM  = 6'(HOURS_DAY);

  logic       load_ok;
  logic       wrap;
  logic       sec_last;
  logic       min_last;
  logic       hour_last;
  logic [5:0] sec_nxt;
  logic [5:0] min_nxt;
  logic [4:0] hour_nxt;
  logic       day_wrap;

  assign load_ok   = ({1'b0, set_hour} < HOUR_LIM) && (set_min < 6'd60) && (set_sec < 6'd60);
  assign wrap      = run_en && (sec_count == PRESC_MAX);
  assign sec_last  = (second == 6'd59);
  assign min_last  = (minute == 6'd59);
  assign hour_last = (hour == HOUR_MAX);

  // Every unit's successor is computed from the current value so one edge carries all of them.
  always_comb begin
    sec_nxt  = sec_last ? 6'd0 : second + 6'd1;
    min_nxt  = minute;
    hour_nxt = hour;
    day_wrap = 1'b0;
    if (sec_last) begin
      min_nxt = min_last ? 6'd0 : minute + 6'd1;
      if (min_last) begin
        hour_nxt = hour_last ? 5'd0 : hour + 5'd1;
        day_wrap = hour_last;
      end
    end
  end

  // A rejected load is a no-op edge: nothing counts, only set_err pulses.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      sec_count <= '0;
      second    <= '0;
      minute    <= '0;
      hour      <= '0;
      sec_tick  <= 1'b0;
      day_tick  <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      day_tick <= 1'b0;
      set_err  <= 1'b0;
      if (set_valid) begin
        if (load_ok) begin
          sec_count <= '0;
          second    <= set_sec;
          minute    <= set_min;
          hour      <= set_hour;
        end else begin
          set_err <= 1'b1;
        end
      end else if (run_en) begin
        if (wrap) begin
          sec_count <= '0;
          second    <= sec_nxt;
          minute    <= min_nxt;
          hour      <= hour_nxt;
          sec_tick  <= 1'b1;
          day_tick  <= day_wrap;
        end else begin
          sec_count <= sec_count + PRESC_W'(1);
        end
      end
    end
  end

  always_comb begin
    disp_hour = hour;
    pm        = 1'b0;
    if (mode_12h) begin
      pm = (hour >= 5'd12);
      if (hour == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour > 5'd12) begin
        disp_hour = hour - 5'd12;
      end
    end
  end

`ifdef RTC_ALARM_EN
  logic alarm_hit;
  logic alarm_q;

  // Only a counting edge can match; sec_nxt is 0 exactly when sec_last.
  assign alarm_hit = alarm_arm && wrap && !set_valid && sec_last &&
                     (hour_nxt == alarm_hour) && (min_nxt == alarm_min);

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      alarm_q <= 1'b0;
    end else if (alarm_hit) begin
      alarm_q <= 1'b1;
    end else if (alarm_clr) begin
      alarm_q <= 1'b0;
    end
  end

  assign alarm_flag = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hour, alarm_min, alarm_arm, alarm_clr};
  assign alarm_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb/tb_rtc_timekeeper.sv - randomized bench for rtc_timekeeper against a seconds-of-day reference model
`timescale 1ns/1ps

module tb_rtc_timekeeper;

  localparam int CLK_HZ = 4;
  localparam int PW     = 3;
  localparam int HD     = 24;
  localparam int DAY    = HD * 3600;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          run_en;
  logic          mode_12h;
  logic          set_valid;
  logic [4:0]    set_hour;
  logic [5:0]    set_min;
  logic [5:0]    set_sec;
  logic          set_err;
  logic [PW-1:0] sec_count;
  logic [5:0]    second;
  logic [5:0]    minute;
  logic [4:0]    hour;
  logic [4:0]    disp_hour;
  logic          pm;
  logic          sec_tick;
  logic          day_tick;
  logic [4:0]    alarm_hour;
  logic [5:0]    alarm_min;
  logic          alarm_arm;
  logic          alarm_clr;
  logic          alarm_flag;

  rtc_timekeeper #(.CLK_HZ(CLK_HZ), .PRESC_W(PW), .HOURS_DAY(HD)) dut (
    .clk(clk), .reset_n(reset_n), .run_en(run_en), .mode_12h(mode_12h),
    .set_valid(set_valid), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_err(set_err), .sec_count(sec_count), .second(second), .minute(minute),
    .hour(hour), .disp_hour(disp_hour), .pm(pm), .sec_tick(sec_tick), .day_tick(day_tick),
    .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_arm(alarm_arm),
    .alarm_clr(alarm_clr), .alarm_flag(alarm_flag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: time as seconds since midnight plus a prescaler phase.
  int tod, pc;
  bit m_stick, m_dtick, m_err, m_alarm;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    tod = 0; pc = 0; m_stick = 0; m_dtick = 0; m_err = 0; m_alarm = 0;
  endtask

  task automatic model_edge();
    bit hit;
    hit = 0;
    m_stick = 0; m_dtick = 0; m_err = 0;
    if (set_valid) begin
      if (int'(set_hour) < HD && int'(set_min) < 60 && int'(set_sec) < 60) begin
        tod = int'(set_hour) * 3600 + int'(set_min) * 60 + int'(set_sec);
        pc  = 0;
      end else begin
        m_err = 1;
      end
    end else if (run_en) begin
      if (pc == CLK_HZ - 1) begin
        pc = 0;
        tod = (tod + 1) % DAY;
        m_stick = 1;
        m_dtick = (tod == 0);
        hit = alarm_arm && (tod == int'(alarm_hour) * 3600 + int'(alarm_min) * 60);
      end else begin
        pc++;
      end
    end
    if (hit) m_alarm = 1;
    else if (alarm_clr) m_alarm = 0;
  endtask

  task automatic compare_all();
    int h, dh;
    h  = tod / 3600;
    dh = mode_12h ? ((h % 12 == 0) ? 12 : h % 12) : h;
    check("sec_count", int'(sec_count), pc);
    check("second", int'(second), tod % 60);
    check("minute", int'(minute), (tod / 60) % 60);
    check("hour", int'(hour), h);
    check("disp_hour", int'(disp_hour), dh);
    check("pm", int'(pm), (mode_12h && h >= 12) ? 1 : 0);
    check("sec_tick", int'(sec_tick), int'(m_stick));
    check("day_tick", int'(day_tick), int'(m_dtick));
    check("set_err", int'(set_err), int'(m_err));
`ifdef RTC_ALARM_EN
    check("alarm_flag", int'(alarm_flag), int'(m_alarm));
`else
    check("alarm_flag", int'(alarm_flag), 0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_load(input int h, input int m, input int s);
    set_valid = 1;
    set_hour = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    step();
    set_valid = 0;
  endtask

  int n_st, n_dt, lat;

  initial begin
    reset_n = 1; run_en = 0; mode_12h = 1; set_valid = 0;
    set_hour = 0; set_min = 0; set_sec = 0;
    alarm_hour = 0; alarm_min = 0; alarm_arm = 0; alarm_clr = 0;
    model_reset();
    #22;
    check("reset_disp12", int'(disp_hour), 12);
    compare_all();
    @(negedge clk);
    reset_n = 0;

    // Asynchronous reset in the middle of a count.
    run_en = 1;
    do_load(5, 6, 7);
    step(); step();
    #2;
    reset_n = 1;
    model_reset();
    #1;
    check("async_rst_hour", int'(hour), 0);
    check("async_rst_disp", int'(disp_hour), 12);
    compare_all();
    #1;
    reset_n = 0;

    // Day wrap from 23:59:58 in 24 h mode.
    mode_12h = 0;
    do_load(23, 59, 58);
    n_st = 0; n_dt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_st += int'(sec_tick);
      n_dt += int'(day_tick);
    end
    check("wrap_sec_ticks", n_st, 2);
    check("wrap_day_ticks", n_dt, 1);
    check("wrap_hour", int'(hour), 0);

    // Out-of-range loads are rejected; noon shows as 12 PM.
    run_en = 0;
    do_load(24, 0, 0);
    check("err_24h", int'(set_err), 1);
    do_load(10, 60, 0);
    check("err_60m", int'(set_err), 1);
    check("err_hold_hour", int'(hour), 0);
    mode_12h = 1;
    do_load(12, 0, 0);
    check("noon_pm", int'(pm), 1);
    check("noon_disp", int'(disp_hour), 12);

    // A load on the wrap edge wins over the increment.
    run_en = 1;
    for (int i = 0; i < 8 && pc != 3; i++) step();
    check("presc_at_3", int'(sec_count), 3);
    do_load(7, 8, 9);
    check("load_wins_tick", int'(sec_tick), 0);
    check("load_wins_sec", int'(second), 9);

    // Freeze, then resume: next second exactly CLK_HZ clocks later.
    do_load(1, 2, 3);
    run_en = 0;
    for (int i = 0; i < 10; i++) step();
    check("freeze_sec", int'(second), 3);
    run_en = 1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (lat == 0 && sec_tick) lat = i + 1;
    end
    check("resume_latency", lat, 4);

`ifdef RTC_ALARM_EN
    alarm_hour = 0; alarm_min = 1; alarm_arm = 1;
    do_load(0, 1, 0);
    check("load_no_alarm", int'(alarm_flag), 0);
    do_load(0, 0, 58);
    for (int i = 0; i < 7; i++) step();
    alarm_clr = 1;
    step();
    check("alarm_set_wins", int'(alarm_flag), 1);
    step();
    alarm_clr = 0;
    check("alarm_cleared", int'(alarm_flag), 0);
    alarm_arm = 0;
`endif

    // Randomized phase, biased toward loads close to the day boundary.
    for (int i = 0; i < 4000; i++) begin
      run_en    = ($urandom_range(0, 9) != 0);
      mode_12h  = 1'($urandom_range(0, 1));
      set_valid = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) begin
        set_hour = 5'(HD - 1 - int'($urandom_range(0, 1)));
        set_min  = 6'(59);
        set_sec  = 6'($urandom_range(55, 59));
      end else begin
        set_hour = 5'($urandom_range(0, 31));
        set_min  = 6'($urandom_range(0, 63));
        set_sec  = 6'($urandom_range(0, 63));
      end
      alarm_arm  = 1'($urandom_range(0, 1));
      alarm_clr  = ($urandom_range(0, 15) == 0);
      alarm_hour = ($urandom_range(0, 1) == 1) ? 5'd0 : 5'($urandom_range(0, 23));
      alarm_min  = ($urandom_range(0, 1) == 1) ? 6'd0 : 6'($urandom_range(0, 59));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
